// File: rtl/frame_addr_seq_if.sv
// Address stream between the frame sequencer and the window/FFT stage.
// The master drives one sample address per transfer (out_valid & out_ready).
interface frame_addr_seq_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned CNT_WIDTH  = 12
);
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CNT_WIDTH-1:0]  sample_idx;
  logic [CNT_WIDTH-1:0]  frame_idx;
  logic                  frame_first;
  logic                  frame_last;

  modport master (
    output out_valid, rd_addr, sample_idx, frame_idx, frame_first, frame_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, rd_addr, sample_idx, frame_idx, frame_first, frame_last,
    output out_ready
  );
endinterface

// File: rtl/frame_addr_seq.sv
// Frame address sequencer: expands one start command into the overlapped
// read-address stream for num_frames frames of a circular sample buffer.
// Optional feature macro: FRAME_SEQ_GAP_EN inserts GAP_CYCLES idle cycles
// between consecutive frames so the downstream FFT pipeline can flush.
module frame_addr_seq #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned CNT_WIDTH  = 12,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [CNT_WIDTH-1:0]  frame_len,
  input  logic [CNT_WIDTH-1:0]  hop_len,
  input  logic [CNT_WIDTH-1:0]  num_frames,
  frame_addr_seq_if.master      out_if,
  output logic                  busy,
  output logic                  done
);

`ifdef FRAME_SEQ_GAP_EN
  typedef enum logic [1:0] {StIdle, StRun, StGap, StFin} state_e;
  localparam int unsigned GapCntW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GapCntW-1:0] gap_cnt_q;
`else
  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;
  // Gap length is meaningless when frames run back-to-back.
  logic unused_gap_cycles;
  assign unused_gap_cycles = ^GAP_CYCLES;
`endif

  localparam logic [CNT_WIDTH-1:0]  CntOne  = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

  state_e                state_q;
  logic [CNT_WIDTH-1:0]  flen_q, hop_q, nfrm_q;
  logic [CNT_WIDTH-1:0]  sidx_q, fidx_q;
  logic [ADDR_WIDTH-1:0] base_q, addr_q;
  logic                  valid_q, first_q, last_q, busy_q, done_q;

  logic                  xfer;
  logic                  last_frame;
  logic [ADDR_WIDTH-1:0] next_base;

  assign xfer       = valid_q & out_if.out_ready;
  assign last_frame = (fidx_q == nfrm_q - CntOne);
  // Base wraps modulo the buffer size; hop is resized to the address width.
  assign next_base  = base_q + ADDR_WIDTH'(hop_q);

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      flen_q    <= '0;
      hop_q     <= '0;
      nfrm_q    <= '0;
      sidx_q    <= '0;
      fidx_q    <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef FRAME_SEQ_GAP_EN
      gap_cnt_q <= '0;
`endif
    end else if (abort) begin
      // Abort wins over start and over a same-cycle transfer; no done pulse.
      state_q <= StIdle;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            flen_q <= frame_len;
            hop_q  <= hop_len;
            nfrm_q <= num_frames;
            sidx_q <= '0;
            fidx_q <= '0;
            base_q <= start_addr;
            addr_q <= start_addr;
            if (frame_len == '0 || num_frames == '0) begin
              // Nothing to issue: finish without ever raising busy.
              state_q <= StFin;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              first_q <= 1'b1;
              last_q  <= (frame_len == CntOne);
            end
          end
        end
        StRun: begin
          if (xfer) begin
            if (last_q) begin
              sidx_q <= '0;
              fidx_q <= fidx_q + CntOne;
              base_q <= next_base;
              addr_q <= next_base;
              if (last_frame) begin
                state_q <= StFin;
                valid_q <= 1'b0;
                first_q <= 1'b0;
                last_q  <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
`ifdef FRAME_SEQ_GAP_EN
                if (GAP_CYCLES != 0) begin
                  state_q   <= StGap;
                  valid_q   <= 1'b0;
                  first_q   <= 1'b0;
                  last_q    <= 1'b0;
                  gap_cnt_q <= '0;
                end else begin
                  first_q <= 1'b1;
                  last_q  <= (flen_q == CntOne);
                end
`else
                first_q <= 1'b1;
                last_q  <= (flen_q == CntOne);
`endif
              end
            end else begin
              sidx_q  <= sidx_q + CntOne;
              addr_q  <= addr_q + AddrOne;
              first_q <= 1'b0;
              last_q  <= (sidx_q + CntOne == flen_q - CntOne);
            end
          end
        end
`ifdef FRAME_SEQ_GAP_EN
        StGap: begin
          // addr_q already holds the next frame base.
          if (gap_cnt_q == GapCntW'(GAP_CYCLES - 1)) begin
            state_q <= StRun;
            valid_q <= 1'b1;
            first_q <= 1'b1;
            last_q  <= (flen_q == CntOne);
          end else begin
            gap_cnt_q <= gap_cnt_q + GapCntW'(1);
          end
        end
`endif
        StFin: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_if.out_valid   = valid_q;
  assign out_if.rd_addr     = addr_q;
  assign out_if.sample_idx  = sidx_q;
  assign out_if.frame_idx   = fidx_q;
  assign out_if.frame_first = first_q;
  assign out_if.frame_last  = last_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule

// File: tb/tb_frame_addr_seq.sv
// Randomized self-checking bench for frame_addr_seq. Expected transfers are
// generated up front from the frame/hop arithmetic and consumed in order.
module tb_frame_addr_seq;
  localparam int unsigned AW = 12;
  localparam int unsigned CW = 12;
  localparam int unsigned GAP_CYCLES = 4;
`ifdef FRAME_SEQ_GAP_EN
  localparam int GapExp = GAP_CYCLES;
`else
  localparam int GapExp = 0;
`endif

  typedef struct {
    int unsigned addr;
    int unsigned sidx;
    int unsigned fidx;
    bit          first;
    bit          last;
  } exp_t;

  logic          clk, rst_n, start, abort;
  logic [AW-1:0] start_addr;
  logic [CW-1:0] frame_len, hop_len, num_frames;
  logic          busy, done;

  int n_vec = 0;
  int n_err = 0;

  frame_addr_seq_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) s_if ();

  frame_addr_seq #(
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .start_addr (start_addr),
    .frame_len  (frame_len),
    .hop_len    (hop_len),
    .num_frames (num_frames),
    .out_if     (s_if),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".out_valid"}, s_if.out_valid, 0);
    check_eq({tag, ".busy"}, busy, 0);
    check_eq({tag, ".done"}, done, 0);
  endtask

  // mode: 0 = always ready, 1 = ready pattern 1,0,0, 2 = random ready.
  // abort_at / restart_at: transfer count at which to abort or re-pulse start (-1 = never).
  task automatic run_job(input int unsigned sa, input int unsigned fl, input int unsigned hl,
                         input int unsigned nf, input int mode, input int abort_at,
                         input int restart_at, input bit fin_restart);
    exp_t q[$];
    exp_t e;
    int   total, n, cyc, idle;
    bit   expect_gap, rdy, xfer;

    for (int f = 0; f < int'(nf); f++) begin
      for (int s = 0; s < int'(fl); s++) begin
        e.addr  = (sa + f * hl + s) % (1 << AW);
        e.sidx  = s;
        e.fidx  = f;
        e.first = (s == 0);
        e.last  = (s == int'(fl) - 1);
        q.push_back(e);
      end
    end
    total = q.size();

    @(negedge clk);
    start      = 1'b1;
    start_addr = AW'(sa);
    frame_len  = CW'(fl);
    hop_len    = CW'(hl);
    num_frames = CW'(nf);
    s_if.out_ready = 1'b0;
    @(negedge clk);
    start      = 1'b0;
    start_addr = AW'($urandom);
    frame_len  = CW'($urandom);
    hop_len    = CW'($urandom);
    num_frames = CW'($urandom);

    if (total == 0) begin
      check_eq("degen.done", done, 1);
      check_eq("degen.busy", busy, 0);
      check_eq("degen.out_valid", s_if.out_valid, 0);
      @(negedge clk);
      check_idle_outputs("degen_after");
      return;
    end

    check_eq("start.busy", busy, 1);
    n = 0; cyc = 0; idle = 0; expect_gap = 0;
    forever begin
      if (cyc++ > 1000) begin
        check_eq("timeout", 1, 0);
        return;
      end
      check_eq("run.done", done, 0);
      check_eq("run.busy", busy, 1);
      if (!s_if.out_valid && expect_gap) begin
        idle++;
      end else begin
        check_eq("run.out_valid", s_if.out_valid, 1);
        if (expect_gap) begin
          check_eq("gap_len", idle, GapExp);
          expect_gap = 0;
        end
        if (s_if.out_valid && q.size() > 0) begin
          check_eq("rd_addr", s_if.rd_addr, q[0].addr);
          check_eq("sample_idx", s_if.sample_idx, q[0].sidx);
          check_eq("frame_idx", s_if.frame_idx, q[0].fidx);
          check_eq("frame_first", s_if.frame_first, q[0].first);
          check_eq("frame_last", s_if.frame_last, q[0].last);
        end
      end

      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 1);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase

      if (n == abort_at) begin
        abort = 1'b1;
        s_if.out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        s_if.out_ready = 1'b0;
        check_idle_outputs("abort");
        @(negedge clk);
        check_idle_outputs("abort_after");
        return;
      end

      start = (n == restart_at);
      s_if.out_ready = rdy;
      xfer = s_if.out_valid && rdy;
      if (xfer) begin
        e = q.pop_front();
        n++;
        if (e.last && q.size() > 0) begin
          expect_gap = 1;
          idle = 0;
        end
      end
      @(negedge clk);
      start = 1'b0;
      if (xfer && q.size() == 0) begin
        s_if.out_ready = 1'b0;
        check_eq("xfer_count", n, total);
        check_eq("fin.done", done, 1);
        check_eq("fin.busy", busy, 0);
        check_eq("fin.out_valid", s_if.out_valid, 0);
        start = fin_restart;
        @(negedge clk);
        start = 1'b0;
        check_idle_outputs("fin_after");
        return;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    start_addr = '0;
    frame_len = '0;
    hop_len = '0;
    num_frames = '0;
    s_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset.out_valid", s_if.out_valid, 0);
    check_eq("reset.rd_addr", s_if.rd_addr, 0);
    check_eq("reset.sample_idx", s_if.sample_idx, 0);
    check_eq("reset.frame_idx", s_if.frame_idx, 0);
    check_eq("reset.frame_first", s_if.frame_first, 0);
    check_eq("reset.frame_last", s_if.frame_last, 0);
    check_eq("reset.busy", busy, 0);
    check_eq("reset.done", done, 0);
    rst_n = 1'b1;

    run_job(0, 4, 2, 3, 0, -1, -1, 0);      // basic overlap
    run_job(4094, 4, 4, 2, 0, -1, -1, 0);   // wrap-around
    run_job(0, 4, 2, 3, 1, -1, -1, 0);      // backpressure 1,0,0
    run_job(0, 3, 3, 2, 0, -1, -1, 0);      // gap shape
    run_job(100, 0, 2, 3, 0, -1, -1, 0);    // frame_len = 0
    run_job(100, 4, 2, 0, 0, -1, -1, 0);    // num_frames = 0
    run_job(10, 4, 2, 3, 0, -1, 5, 1);      // ignored starts mid-run and in FIN
    run_job(20, 4, 2, 3, 0, 5, -1, 0);      // abort in frame 1 of 3
    run_job(30, 1, 0, 3, 2, -1, -1, 0);     // single-sample frames, hop 0
    run_job(40, 3, 7, 3, 2, -1, -1, 0);     // hop > frame_len

    // Asynchronous reset mid-run.
    @(negedge clk);
    start = 1'b1; start_addr = 12'd50; frame_len = 12'd8; hop_len = 12'd3; num_frames = 12'd3;
    s_if.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid.out_valid", s_if.out_valid, 0);
    check_eq("rst_mid.rd_addr", s_if.rd_addr, 0);
    check_eq("rst_mid.sample_idx", s_if.sample_idx, 0);
    check_eq("rst_mid.frame_idx", s_if.frame_idx, 0);
    check_eq("rst_mid.frame_first", s_if.frame_first, 0);
    check_eq("rst_mid.frame_last", s_if.frame_last, 0);
    check_eq("rst_mid.busy", busy, 0);
    check_eq("rst_mid.done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    s_if.out_ready = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_release");

    for (int j = 0; j < 30; j++) begin
      int unsigned fl, nf;
      fl = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      nf = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      run_job($urandom_range(0, (1 << AW) - 1), fl, $urandom_range(0, 8), nf,
              $urandom_range(0, 2), -1, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
